// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with a frame-stable packed-BCD snapshot.
// Optional build macro SEG_LZB_EN enables leading-zero blanking of digits 3..1.
module seg7_scan_driver #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int SCAN_HZ    = 1000,
   parameter int SCAN_TICK  = CLOCK_FREQ / SCAN_HZ
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] segments,
   input  logic [3:0]  dp_mask,
   input  logic        enable,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int CNT_W = (SCAN_TICK > 2) ? $clog2(SCAN_TICK) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SCAN_TICK - 1);

   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [15:0]      snap_q, snap_d;
   logic [3:0]       dp_snap_q, dp_snap_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             tick_s;
   logic             blank_s;
   logic [3:0]       nib_s;

   function automatic logic [6:0] decode_bcd(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'd0:    pat = 7'b1000000;
         4'd1:    pat = 7'b1111001;
         4'd2:    pat = 7'b0100100;
         4'd3:    pat = 7'b0110000;
         4'd4:    pat = 7'b0011001;
         4'd5:    pat = 7'b0010010;
         4'd6:    pat = 7'b0000010;
         4'd7:    pat = 7'b1111000;
         4'd8:    pat = 7'b0000000;
         4'd9:    pat = 7'b0010000;
         default: pat = 7'b0111111;
      endcase
      return pat;
   endfunction

   // Prescaler, digit index, frame snapshot and next output image.
   always_comb begin
      tick_s     = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick_s ? '0 : tick_cnt_q + CNT_W'(1);
      idx_d      = tick_s ? idx_q + 2'd1 : idx_q;
      snap_d     = snap_q;
      dp_snap_d  = dp_snap_q;
      if (tick_s && (idx_q == 2'd3)) begin
         snap_d    = segments;
         dp_snap_d = dp_mask;
      end else begin
         snap_d    = snap_q;
         dp_snap_d = dp_snap_q;
      end

      nib_s = snap_q[4*idx_q +: 4];
`ifdef SEG_LZB_EN
      case (idx_q)
         2'd3:    blank_s = (snap_q[15:12] == 4'h0);
         2'd2:    blank_s = (snap_q[15:8] == 8'h00);
         2'd1:    blank_s = (snap_q[15:4] == 12'h000);
         default: blank_s = 1'b0;
      endcase
`else
      blank_s = 1'b0;
`endif

      // Anode and cathodes are produced together so they always update on the same edge.
      if (enable) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = blank_s ? 7'b1111111 : decode_bcd(nib_s);
         dp_d  = ~dp_snap_q[idx_q];
      end else begin
         an_d  = 4'b1111;
         seg_d = 7'b1111111;
         dp_d  = 1'b1;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tick_cnt_q <= '0;
         idx_q      <= 2'd0;
         snap_q     <= 16'h0000;
         dp_snap_q  <= 4'h0;
         an_q       <= 4'b1111;
         seg_q      <= 7'b1111111;
         dp_q       <= 1'b1;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         idx_q      <= idx_d;
         snap_q     <= snap_d;
         dp_snap_q  <= dp_snap_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_TICK = 4); honours SEG_LZB_EN when defined.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] segments;
   logic [3:0]  dp_mask;
   logic        enable;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } obs_t;

   obs_t exp_q[$];
   obs_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   int          m_cnt  = 0;
   logic [15:0] m_snap = 16'h0000;
   logic [3:0]  m_dps  = 4'h0;

   seg7_scan_driver #(.CLOCK_FREQ(400), .SCAN_HZ(100)) dut (
      .clk(clk), .resetn(resetn), .segments(segments), .dp_mask(dp_mask),
      .enable(enable), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_pat(input logic [3:0] nib);
      logic [6:0] p;
      case (nib)
         4'd0: p = 7'b1000000;  4'd1: p = 7'b1111001;
         4'd2: p = 7'b0100100;  4'd3: p = 7'b0110000;
         4'd4: p = 7'b0011001;  4'd5: p = 7'b0010010;
         4'd6: p = 7'b0000010;  4'd7: p = 7'b1111000;
         4'd8: p = 7'b0000000;  4'd9: p = 7'b0010000;
         default: p = 7'b0111111;
      endcase
      return p;
   endfunction

   // One clock edge: predict what the output registers take on this edge and queue it.
   task automatic cycle();
      obs_t e;
      int   idx;
      logic blank;
      @(posedge clk);
      if (!resetn) begin
         e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
         m_cnt  = 0;
         m_snap = 16'h0000;
         m_dps  = 4'h0;
      end else begin
         idx   = (m_cnt / 4) % 4;
         blank = 1'b0;
`ifdef SEG_LZB_EN
         if (idx != 0) begin
            blank = 1'b1;
            for (int d = 3; d >= idx; d--)
               if (m_snap[d*4 +: 4] != 4'h0) blank = 1'b0;
         end
`endif
         if (enable) begin
            case (idx)
               0: e.an = 4'b1110;
               1: e.an = 4'b1101;
               2: e.an = 4'b1011;
               default: e.an = 4'b0111;
            endcase
            e.seg = blank ? 7'b1111111 : exp_pat(m_snap[idx*4 +: 4]);
            e.dp  = ~m_dps[idx];
         end else begin
            e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1};
         end
         m_cnt++;
         if (m_cnt % 16 == 0) begin
            m_snap = segments;
            m_dps  = dp_mask;
         end
      end
      exp_q.push_back(e);
      #1;
   endtask

   // Monitor: compare the registered outputs mid-cycle against the queued prediction.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         if ({an, seg, dp} !== mon_e) begin
            n_errors++;
            $display("FAIL scan_out t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     $time, an, seg, dp, mon_e.an, mon_e.seg, mon_e.dp);
         end
      end
   end

   initial begin
      resetn   = 1'b0;
      enable   = 1'b0;
      segments = 16'h1234;
      dp_mask  = 4'b0100;
      repeat (3) cycle();

      // Frame 0 shows "0" everywhere; frame 1 shows 1234 with dp on digit 2.
      resetn = 1'b1;
      enable = 1'b1;
      repeat (32) cycle();

      // 1111 loads at the end of frame 2; switch to 2222 while idx = 1 of frame 3.
      segments = 16'h1111;
      dp_mask  = 4'b0000;
      repeat (16) cycle();
      repeat (4) cycle();
      segments = 16'h2222;
      repeat (12) cycle();
      repeat (16) cycle();

      // Invalid BCD, then a 5-cycle dark gap mid-frame.
      segments = 16'hA9F0;
      dp_mask  = 4'b1001;
      repeat (16) cycle();
      repeat (22) cycle();
      enable = 1'b0;
      repeat (5) cycle();
      enable = 1'b1;
      repeat (21) cycle();

      // Mid-frame reset while idx = 2.
      for (int i = 0; i < 16 && ((m_cnt / 4) % 4) != 2; i++) cycle();
      resetn = 1'b0;
      cycle();
      resetn = 1'b1;
      repeat (20) cycle();

      // Leading-zero patterns.
      segments = 16'h0050;
      repeat (32) cycle();
      segments = 16'h0000;
      repeat (32) cycle();

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
